// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: run enables, modes, divisor load
// handshake and the per-channel divided outputs.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
);
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic                    load_req;
  logic                    load_busy;
  logic                    load_ack;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;

  modport master (
    output enable, mode, div_val, load_req,
    input  load_busy, load_ack, clk_out, tick
  );

  modport slave (
    input  enable, mode, div_val, load_req,
    output load_busy, load_ack, clk_out, tick
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: per channel a square-wave or one-cycle
// pulse output plus a wrap tick; divisor updates are deferred to the next wrap.
module clk_div_multi #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 2000000
) (
  input logic             clk,
  input logic             reset,
  clk_div_multi_if.slave  bus
);

  logic              load_busy_q;
  logic              load_ack_q;
  logic              accept;
  logic [NUM_CH-1:0] pend_valid;
  logic [NUM_CH-1:0] clk_out_v;
  logic [NUM_CH-1:0] tick_v;

  assign accept = bus.load_req && !load_busy_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] act_div_q;
    logic [CNT_W-1:0] pend_div_q;
    logic             pend_valid_q;
    logic             mode_act_q;
    logic             clk_out_q;
    logic             tick_q;
    logic             wrap;

    assign wrap = (cnt_q == act_div_q);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q        <= '0;
        act_div_q    <= CNT_W'(DEFAULT_DIV);
        pend_div_q   <= '0;
        pend_valid_q <= 1'b0;
        mode_act_q   <= 1'b0;
        clk_out_q    <= 1'b0;
        tick_q       <= 1'b0;
      end else begin
        // accept only happens while no channel holds a pending value
        if (accept) begin
          pend_div_q   <= bus.div_val[g*CNT_W +: CNT_W];
          pend_valid_q <= 1'b1;
        end
        if (!bus.enable[g]) begin
          cnt_q      <= '0;
          clk_out_q  <= 1'b0;
          tick_q     <= 1'b0;
          mode_act_q <= bus.mode[g];
          if (pend_valid_q) begin
            act_div_q    <= pend_div_q;
            pend_valid_q <= 1'b0;
          end
        end else if (wrap) begin
          cnt_q      <= '0;
          tick_q     <= 1'b1;
          mode_act_q <= bus.mode[g];
          // entering pulse mode from square mode yields a low output at this wrap
          if (bus.mode[g]) clk_out_q <= mode_act_q;
          else             clk_out_q <= ~clk_out_q;
          if (pend_valid_q) begin
            act_div_q    <= pend_div_q;
            pend_valid_q <= 1'b0;
          end
        end else begin
          cnt_q  <= cnt_q + CNT_W'(1);
          tick_q <= 1'b0;
          if (mode_act_q) clk_out_q <= 1'b0;
        end
      end
    end

    assign pend_valid[g] = pend_valid_q;
    assign clk_out_v[g]  = clk_out_q;
    assign tick_v[g]     = tick_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_busy_q <= 1'b0;
      load_ack_q  <= 1'b0;
    end else begin
      load_ack_q <= 1'b0;
      if (accept) begin
        load_busy_q <= 1'b1;
      end else if (load_busy_q && (pend_valid == '0)) begin
        load_busy_q <= 1'b0;
        load_ack_q  <= 1'b1;
      end
    end
  end

  assign bus.load_busy = load_busy_q;
  assign bus.load_ack  = load_ack_q;
  assign bus.clk_out   = clk_out_v;
  assign bus.tick      = tick_v;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with two 8-bit channels and a reset divisor of 3.
module tb_clk_div_multi;
  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable = 2'b00; bus.mode = 2'b00; bus.div_val = '0; bus.load_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.clk_out, bus.tick, bus.load_busy, bus.load_ack} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=%b", {bus.clk_out, bus.tick, bus.load_busy, bus.load_ack}, 6'b0);
    end
    bus.enable = 2'b11;
    reset = 1'b1;
    cyc = 0;
  endtask

  // Both channels square mode, divisor 3: tick every 4 cycles, clk_out period 8.
  task automatic test_square(input bit expect_quiet_ack);
    logic [5:0] exp;
    for (int i = 0; i < 12; i++) begin
      step();
      exp = {(((cyc / 4) % 2) == 1) ? 2'b11 : 2'b00, (cyc % 4 == 0) ? 2'b11 : 2'b00, 2'b00};
      n_checks++;
      if ({bus.clk_out, bus.tick, bus.load_busy, bus.load_ack} !== exp) begin
        n_fail++;
        $display("FAIL square%s cyc=%0d got=%b exp=%b", expect_quiet_ack ? "_after_reset" : "", cyc,
                 {bus.clk_out, bus.tick, bus.load_busy, bus.load_ack}, exp);
      end
    end
  endtask

  task automatic test_pulse_mode();
    logic [1:0] ec, et;
    bus.mode = 2'b10;
    for (int i = 0; i < 12; i++) begin
      step();
      et    = (cyc % 4 == 0) ? 2'b11 : 2'b00;
      ec[0] = ((cyc / 4) % 2) == 1;
      ec[1] = (cyc < 16) ? (((cyc / 4) % 2) == 1) : ((cyc % 4 == 0) && (cyc >= 20));
      n_checks++;
      if ({bus.clk_out, bus.tick} !== {ec, et}) begin
        n_fail++;
        $display("FAIL pulse_mode cyc=%0d got=%b exp=%b", cyc, {bus.clk_out, bus.tick}, {ec, et});
      end
    end
  endtask

  // Load {ch1=0, ch0=9} mid-period, then a second request while busy that must be ignored.
  task automatic test_load_back_to_back();
    logic [1:0] ec, et;
    logic       eb, ea;
    int         acks;
    acks = 0;
    bus.mode = 2'b00;
    step();
    bus.div_val = {8'd0, 8'd9};
    bus.load_req = 1'b1;
    step();
    n_checks++;
    if ({bus.load_busy, bus.load_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL load_accept got=%b exp=%b", {bus.load_busy, bus.load_ack}, 2'b10);
    end
    bus.div_val = {8'd5, 8'd5};
    step();
    bus.load_req = 1'b0;
    for (int i = 0; i < 21; i++) begin
      step();
      et[0] = (cyc == 28) || (cyc == 38) || (cyc == 48);
      et[1] = 1'b1;
      ec[0] = ((cyc >= 28) && (cyc < 38)) || (cyc >= 48);
      ec[1] = (cyc % 2 == 0);
      eb    = (cyc <= 28);
      ea    = (cyc == 29);
      if (bus.load_ack === 1'b1) acks++;
      n_checks++;
      if ({bus.clk_out, bus.tick, bus.load_busy, bus.load_ack} !== {ec, et, eb, ea}) begin
        n_fail++;
        $display("FAIL load_apply cyc=%0d got=%b exp=%b", cyc,
                 {bus.clk_out, bus.tick, bus.load_busy, bus.load_ack}, {ec, et, eb, ea});
      end
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL load_ack_count got=%0d exp=1", acks);
    end
  endtask

  // Load {ch1=1, ch0=2} with ch0 disabled: ch0 adopts at once, then restarts on re-enable.
  task automatic test_disable_pending();
    logic [5:0] exp_tab [8];
    exp_tab = '{6'b10_10_10, 6'b10_00_01, 6'b00_10_00, 6'b00_00_00,
                6'b10_10_00, 6'b10_00_00, 6'b00_10_00, 6'b01_01_00};
    bus.div_val = {8'd1, 8'd2};
    bus.load_req = 1'b1;
    step();
    bus.load_req = 1'b0;
    bus.enable = 2'b10;
    n_checks++;
    if (bus.load_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL disable_busy got=%b exp=1", bus.load_busy);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ({bus.clk_out, bus.tick, bus.load_busy, bus.load_ack} !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL disable_pending cyc=%0d got=%b exp=%b", cyc,
                 {bus.clk_out, bus.tick, bus.load_busy, bus.load_ack}, exp_tab[i]);
      end
      if (cyc == 54) bus.enable = 2'b11;
    end
  endtask

  task automatic test_reset_mid();
    bus.div_val = {8'd7, 8'd7};
    bus.load_req = 1'b1;
    step();
    bus.load_req = 1'b0;
    n_checks++;
    if ({bus.load_busy, bus.clk_out[1]} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset got=%b exp=%b", {bus.load_busy, bus.clk_out[1]}, 2'b11);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.clk_out, bus.tick, bus.load_busy, bus.load_ack} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=%b", {bus.clk_out, bus.tick, bus.load_busy, bus.load_ack}, 6'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    test_square(1'b1);
  endtask

  initial begin
    test_reset();
    test_square(1'b0);
    test_pulse_mode();
    test_load_back_to_back();
    test_disable_pending();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
